// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for a 5-stage pipeline with a multi-cycle
// execute unit, x0-aware hazard detection and a sticky branch-redirect latch.
module hazard_ctrl_mc #(
   parameter int unsigned NREAD  = 2,
   parameter int unsigned MC_LAT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_wait,
   input  logic                 d_wait,
   input  logic                 dbranch,
   input  logic                 mc_startE,
   input  logic [NREAD*5-1:0]   ra_d,
   input  logic [NREAD*5-1:0]   ra_e,
   input  logic [4:0]           edst,
   input  logic [4:0]           mdst,
   input  logic [4:0]           wdst,
   input  logic                 wrE,
   input  logic                 wrM,
   input  logic                 wrW,
   input  logic                 memrdE,
   input  logic                 memrdM,
   output logic                 stallF,
   output logic                 stallD,
   output logic                 stallE,
   output logic                 stallM,
   output logic                 flushD,
   output logic                 flushE,
   output logic                 flushM,
   output logic                 flushW,
   output logic [NREAD-1:0]     fwd_d,
   output logic [2*NREAD-1:0]   fwd_e,
   output logic                 mc_busy
);

   localparam int unsigned CW = $clog2(MC_LAT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MC_LAT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;

   logic          hit_e;     // some D operand produced by E
   logic          hit_m;     // some D operand produced by M
   logic          lw_haz;
   logic          br_haz;
   logic          mc_run;

   // Register x0 is hardwired zero and never creates a dependency.
   function automatic logic reg_match(input logic [4:0] r, input logic [4:0] d);
      return (r != 5'd0) && (r == d);
   endfunction

   // Operand dependency detection and forward-select generation.
   always_comb begin
      hit_e = 1'b0;
      hit_m = 1'b0;
      fwd_d = '0;
      fwd_e = '0;
      for (int i = 0; i < int'(NREAD); i++) begin
         if (reg_match(ra_d[5*i +: 5], edst)) hit_e = 1'b1;
         if (reg_match(ra_d[5*i +: 5], mdst)) hit_m = 1'b1;
         if (!reset) begin
            fwd_d[i] = reg_match(ra_d[5*i +: 5], mdst) && wrM;
            if (reg_match(ra_e[5*i +: 5], mdst) && wrM)
               fwd_e[2*i +: 2] = 2'b10;
            else if (reg_match(ra_e[5*i +: 5], wdst) && wrW)
               fwd_e[2*i +: 2] = 2'b01;
         end
      end
   end

   // Prioritised control mode: data wait, multi-cycle op, fetch wait, normal.
   always_comb begin
      stallF  = 1'b0;
      stallD  = 1'b0;
      stallE  = 1'b0;
      stallM  = 1'b0;
      flushD  = 1'b0;
      flushE  = 1'b0;
      flushM  = 1'b0;
      flushW  = 1'b0;
      mc_busy = 1'b0;
      cnt_d   = cnt_q;
      pend_d  = pend_q;

      mc_run = mc_startE && (cnt_q != CNT_LAST);
      lw_haz = memrdE && wrE && hit_e;
      br_haz = dbranch && ((wrE && hit_e) || (memrdM && hit_m));

      if (!reset) begin
         if (d_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else begin
            // Count only while E holds a multi-cycle op; wrap on completion.
            cnt_d = mc_run ? cnt_q + CW'(1) : '0;
            if (mc_run) begin
               mc_busy = 1'b1;
               stallF  = 1'b1;
               stallD  = 1'b1;
               stallE  = 1'b1;
               flushM  = 1'b1;
            end else if (i_wait) begin
               // A redirect seen while fetch waits is remembered until fetch resumes.
               flushD = 1'b1;
               if (dbranch || pend_q) begin
                  pend_d = 1'b1;
               end else begin
                  stallF = 1'b1;
               end
            end else begin
               stallF = lw_haz || br_haz;
               stallD = lw_haz || br_haz;
               flushE = lw_haz || br_haz;
               flushD = (dbranch || pend_q) && !(lw_haz || br_haz);
               pend_d = 1'b0;
            end
         end
      end
   end

   // Stall counter and pending-redirect state.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed scenarios plus randomized traffic
// checked against a behavioural model, for MC_LAT=4 and MC_LAT=1.
module tb_hazard_ctrl_mc;

   logic clk = 1'b0;
   logic reset, i_wait, d_wait, dbranch, mc_startE;
   logic [9:0] ra_d, ra_e;
   logic [4:0] edst, mdst, wdst;
   logic wrE, wrM, wrW, memrdE, memrdM;

   logic a_sF, a_sD, a_sE, a_sM, a_fD, a_fE, a_fM, a_fW, a_busy;
   logic [1:0] a_fwd_d;
   logic [3:0] a_fwd_e;
   logic b_sF, b_sD, b_sE, b_sM, b_fD, b_fE, b_fM, b_fW, b_busy;
   logic [1:0] b_fwd_d;
   logic [3:0] b_fwd_e;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl_mc #(.NREAD(2), .MC_LAT(4)) dut4 (
      .clk(clk), .reset(reset), .i_wait(i_wait), .d_wait(d_wait), .dbranch(dbranch),
      .mc_startE(mc_startE), .ra_d(ra_d), .ra_e(ra_e), .edst(edst), .mdst(mdst),
      .wdst(wdst), .wrE(wrE), .wrM(wrM), .wrW(wrW), .memrdE(memrdE), .memrdM(memrdM),
      .stallF(a_sF), .stallD(a_sD), .stallE(a_sE), .stallM(a_sM), .flushD(a_fD),
      .flushE(a_fE), .flushM(a_fM), .flushW(a_fW), .fwd_d(a_fwd_d), .fwd_e(a_fwd_e),
      .mc_busy(a_busy));

   hazard_ctrl_mc #(.NREAD(2), .MC_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .i_wait(i_wait), .d_wait(d_wait), .dbranch(dbranch),
      .mc_startE(mc_startE), .ra_d(ra_d), .ra_e(ra_e), .edst(edst), .mdst(mdst),
      .wdst(wdst), .wrE(wrE), .wrM(wrM), .wrW(wrW), .memrdE(memrdE), .memrdM(memrdM),
      .stallF(b_sF), .stallD(b_sD), .stallE(b_sE), .stallM(b_sM), .flushD(b_fD),
      .flushE(b_fE), .flushM(b_fM), .flushW(b_fW), .fwd_d(b_fwd_d), .fwd_e(b_fwd_e),
      .mc_busy(b_busy));

   // Packed view: {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW,mc_busy,fwd_d,fwd_e}
   wire [14:0] o4 = {a_sF, a_sD, a_sE, a_sM, a_fD, a_fE, a_fM, a_fW, a_busy, a_fwd_d, a_fwd_e};
   wire [14:0] o1 = {b_sF, b_sD, b_sE, b_sM, b_fD, b_fE, b_fM, b_fW, b_busy, b_fwd_d, b_fwd_e};

   // Model state: cycles the current op has spent in E, and the pending redirect flag.
   int m4_cnt = 0, m1_cnt = 0;
   bit m4_pend = 1'b0, m1_pend = 1'b0;

   function automatic logic [14:0] model_out(int lat, int cnt, bit pend);
      logic sF, sD, sE, sM, fD, fE, fM, fW, busy, dep_e, dep_m, haz;
      logic [1:0] fd;
      logic [3:0] fe;
      logic [4:0] rd, re;
      {sF, sD, sE, sM, fD, fE, fM, fW, busy} = '0;
      fd = '0; fe = '0; dep_e = 1'b0; dep_m = 1'b0;
      if (reset) return 15'd0;
      for (int i = 0; i < 2; i++) begin
         rd = ra_d[5*i +: 5];
         re = ra_e[5*i +: 5];
         if (rd != 0 && rd == edst) dep_e = 1'b1;
         if (rd != 0 && rd == mdst) dep_m = 1'b1;
         fd[i] = (rd != 0 && rd == mdst && wrM);
         if (re != 0 && re == mdst && wrM) fe[2*i +: 2] = 2'b10;
         else if (re != 0 && re == wdst && wrW) fe[2*i +: 2] = 2'b01;
      end
      if (d_wait) begin
         {sF, sD, sE, sM, fW} = 5'b11111;
      end else if (mc_startE && cnt < lat - 1) begin
         {busy, sF, sD, sE, fM} = 5'b11111;
      end else if (i_wait) begin
         fD = 1'b1;
         sF = !(dbranch || pend);
      end else begin
         haz = (memrdE && wrE && dep_e) || (dbranch && ((wrE && dep_e) || (memrdM && dep_m)));
         sF = haz; sD = haz; fE = haz;
         fD = (dbranch || pend) && !haz;
      end
      return {sF, sD, sE, sM, fD, fE, fM, fW, busy, fd, fe};
   endfunction

   // Model state advance, from the values presented during the cycle.
   always @(posedge clk) begin
      if (reset) begin
         m4_cnt <= 0; m4_pend <= 1'b0; m1_cnt <= 0; m1_pend <= 1'b0;
      end else if (!d_wait) begin
         m4_cnt <= mc_startE ? (m4_cnt + 1) % 4 : 0;
         m1_cnt <= mc_startE ? (m1_cnt + 1) % 1 : 0;
         if (!(mc_startE && m4_cnt < 3))
            m4_pend <= i_wait ? (m4_pend | dbranch) : 1'b0;
         m1_pend <= i_wait ? (m1_pend | dbranch) : 1'b0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      {i_wait, d_wait, dbranch, mc_startE} = '0;
      ra_d = '0; ra_e = '0; edst = '0; mdst = '0; wdst = '0;
      {wrE, wrM, wrW, memrdE, memrdM} = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      i_wait = 1'b1; d_wait = 1'b1; mc_startE = 1'b1;
      ra_e = {5'd3, 5'd3}; mdst = 5'd3; wrM = 1'b1;
      cyc(); cyc();
      #4;
      checks++;
      if (o4 !== 15'd0) begin errors++; $display("FAIL reset_outs4 got %h want %h", o4, 15'd0); end
      checks++;
      if (o1 !== 15'd0) begin errors++; $display("FAIL reset_outs1 got %h want %h", o1, 15'd0); end
      cyc();
      reset = 1'b0;
      idle_inputs();
      cyc();
   endtask

   task automatic test_forward();
      idle_inputs();
      ra_e = {5'd5, 5'd3}; mdst = 5'd3; wrM = 1'b1; wdst = 5'd5; wrW = 1'b1;
      #4;
      checks++;
      if (a_fwd_e !== 4'b0110) begin errors++; $display("FAIL fwd_e_mw got %b want %b", a_fwd_e, 4'b0110); end
      cyc();
      mdst = 5'd0; ra_e = {5'd5, 5'd0};
      #4;
      checks++;
      if (a_fwd_e !== 4'b0100) begin errors++; $display("FAIL fwd_e_x0 got %b want %b", a_fwd_e, 4'b0100); end
      cyc();
      ra_d = {5'd9, 5'd0}; mdst = 5'd9;
      #4;
      checks++;
      if (a_fwd_d !== 2'b10) begin errors++; $display("FAIL fwd_d got %b want %b", a_fwd_d, 2'b10); end
      cyc();
      idle_inputs();
      wrM = 1'b1;
      #4;
      checks++;
      if (a_fwd_d !== 2'b00) begin errors++; $display("FAIL fwd_d_x0 got %b want %b", a_fwd_d, 2'b00); end
      cyc();
   endtask

   task automatic test_load_use();
      idle_inputs();
      memrdE = 1'b1; wrE = 1'b1; edst = 5'd7; ra_d = {5'd7, 5'd1};
      #4;
      checks++;
      if ({a_sF, a_sD, a_fE, a_fD} !== 4'b1110) begin
         errors++; $display("FAIL load_use got %b want %b", {a_sF, a_sD, a_fE, a_fD}, 4'b1110);
      end
      cyc();
      edst = 5'd0; ra_d = {5'd0, 5'd1};
      #4;
      checks++;
      if ({a_sF, a_sD, a_fE} !== 3'b000) begin
         errors++; $display("FAIL load_use_x0 got %b want %b", {a_sF, a_sD, a_fE}, 3'b000);
      end
      cyc();
      idle_inputs();
      dbranch = 1'b1; wrE = 1'b1; edst = 5'd4; ra_d = {5'd0, 5'd4};
      #4;
      checks++;
      if ({a_sF, a_sD, a_fE, a_fD} !== 4'b1110) begin
         errors++; $display("FAIL branch_haz got %b want %b", {a_sF, a_sD, a_fE, a_fD}, 4'b1110);
      end
      cyc();
      idle_inputs();
      cyc();
   endtask

   task automatic test_back_to_back_mc();
      logic want;
      idle_inputs();
      mc_startE = 1'b1;
      for (int k = 0; k < 8; k++) begin
         want = ((k % 4) != 3);
         #4;
         checks++;
         if ({a_busy, a_sF, a_sD, a_sE, a_fM} !== {5{want}}) begin
            errors++; $display("FAIL mc_busy4 cyc%0d got %b want %b", k, {a_busy, a_sF, a_sD, a_sE, a_fM}, {5{want}});
         end
         checks++;
         if (b_busy !== 1'b0) begin errors++; $display("FAIL mc_busy1 cyc%0d got %b want 0", k, b_busy); end
         cyc();
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_ifetch_redirect();
      idle_inputs();
      i_wait = 1'b1;
      #4;
      checks++;
      if ({a_sF, a_fD} !== 2'b11) begin errors++; $display("FAIL iwait_plain got %b want %b", {a_sF, a_fD}, 2'b11); end
      cyc();
      dbranch = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #4;
         checks++;
         if ({a_sF, a_fD} !== 2'b01) begin
            errors++; $display("FAIL iwait_redir cyc%0d got %b want %b", k, {a_sF, a_fD}, 2'b01);
         end
         cyc();
         dbranch = 1'b0;
      end
      i_wait = 1'b0;
      #4;
      checks++;
      if ({a_sF, a_fD} !== 2'b01) begin errors++; $display("FAIL redir_release got %b want %b", {a_sF, a_fD}, 2'b01); end
      cyc();
      #4;
      checks++;
      if (a_fD !== 1'b0) begin errors++; $display("FAIL pend_clear got %b want 0", a_fD); end
      cyc();
   endtask

   task automatic test_dwait_freeze();
      idle_inputs();
      mc_startE = 1'b1;
      cyc();
      d_wait = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #4;
         checks++;
         if ({a_sF, a_sD, a_sE, a_sM, a_fW, a_fM} !== 6'b111110) begin
            errors++; $display("FAIL dwait cyc%0d got %b want %b", k, {a_sF, a_sD, a_sE, a_sM, a_fW, a_fM}, 6'b111110);
         end
         cyc();
      end
      d_wait = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #4;
         checks++;
         if (a_busy !== (k < 2)) begin errors++; $display("FAIL dwait_resume cyc%0d got %b want %b", k, a_busy, k < 2); end
         cyc();
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      i_wait = 1'b1; dbranch = 1'b1;
      cyc();
      dbranch = 1'b0; mc_startE = 1'b1;
      cyc();
      reset = 1'b1;
      #4;
      checks++;
      if (o4 !== 15'd0) begin errors++; $display("FAIL reset_mid_outs got %h want %h", o4, 15'd0); end
      cyc();
      reset = 1'b0; i_wait = 1'b0; mc_startE = 1'b0;
      #4;
      checks++;
      if (a_fD !== 1'b0) begin errors++; $display("FAIL reset_mid_pend got %b want 0", a_fD); end
      cyc();
      mc_startE = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #4;
         checks++;
         if (a_busy !== (k < 3)) begin errors++; $display("FAIL reset_mid_cnt cyc%0d got %b want %b", k, a_busy, k < 3); end
         cyc();
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_random();
      logic [14:0] e4, e1;
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 59) == 0);
         d_wait    = ($urandom_range(0, 7) == 0);
         i_wait    = ($urandom_range(0, 4) == 0);
         dbranch   = ($urandom_range(0, 5) == 0);
         mc_startE = ($urandom_range(0, 2) != 0);
         ra_d = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
         ra_e = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
         edst = 5'($urandom_range(0, 6));
         mdst = 5'($urandom_range(0, 6));
         wdst = 5'($urandom_range(0, 6));
         {wrE, wrM, wrW, memrdE, memrdM} = 5'($urandom);
         #4;
         e4 = model_out(4, m4_cnt, m4_pend);
         e1 = model_out(1, m1_cnt, m1_pend);
         checks++;
         if (o4 !== e4) begin errors++; $display("FAIL rand4 n%0d got %b want %b", n, o4, e4); end
         checks++;
         if (o1 !== e1) begin errors++; $display("FAIL rand1 n%0d got %b want %b", n, o1, e1); end
         cyc();
      end
      reset = 1'b0;
      idle_inputs();
      cyc();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_forward();
      test_load_use();
      test_back_to_back_mc();
      test_ifetch_redirect();
      test_dwait_freeze();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
